spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- SPI peripheral-side shift engine: the far end of the link driven by the master clock/SCK generator.
- Oversamples external sck, ss_n and mosi in the system clk domain and deserialises mosi into DATA_W-bit words.
- Serialises a host-loaded word onto miso; honours the same cpol/cpha/bit-order settings as the master.
- Requires clk ≥ 4× sck frequency.

Parameters:
- DATA_W, 8, frame width in bits (2..16).
- FILL, all-ones, word shifted out when no tx word is pending.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- cpol  input  1  sck idle level; static while ss_n is low.
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
- lsbfe  input  1  1: LSB first; 0: MSB first.
- sck  input  1  external serial clock (asynchronous).
- ss_n  input  1  external slave select, active low (asynchronous).
- mosi  input  1  serial data in (asynchronous).
- miso  output  1  serial data out.
- miso_oe  output  1  miso drive enable.
- tx_data  input  DATA_W  word to transmit.
- tx_load  input  1  write strobe for tx_data.
- tx_ready  output  1  tx holding register empty.
- rx_data  output  DATA_W  last received word.
- rx_valid  output  1  rx_data holds an unacknowledged word.
- rx_ack  input  1  clears rx_valid.
- busy  output  1  frame in progress.

Behaviour:
- Reset (async, rst=1):
  - miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0.
  - Bit counter=0; state=IDLE; synchronisers load idle values (sck=cpol, ss_n=1, mosi=0).
  - Reset mid-frame discards all partial data.
- Synchronisation:
  - 2-flop synchroniser on each of sck, ss_n, mosi.
  - Edge detection uses the synchronised sck and its 1-cycle-delayed copy.
  - Leading edge = transition away from cpol; trailing edge = transition back to cpol.
  - Pin-to-internal-event latency is 3 clk.
- States:
  - IDLE: ss_n_sync=1. miso_oe=0, busy=0, bit counter held at 0. On ss_n_sync falling, load the shift register and go to ACTIVE.
  - ACTIVE: miso_oe=1, busy=1.
    - Sample edge (leading if cpha=0, trailing if cpha=1): capture mosi_sync into the rx shift register, increment the bit counter.
    - Shift edge (the opposite edge): advance the tx shift register. With cpha=1, the first leading edge of each frame does not shift.
    - When the counter reaches DATA_W on a sample edge: rx_data <= assembled word, rx_valid=1 on the next clk, counter wraps to 0.
    - Next frame: the tx shift register reloads on the following shift edge (cpha=0) or immediately (cpha=1).
    - ss_n staying low means back-to-back frames with no gap.
    - On ss_n_sync rising, go to IDLE.
- miso: combinational from the tx shift register, MSB if lsbfe=0, else LSB.
- Tx shift-register load:
  - If tx_ready=0, load the holding register and set tx_ready=1.
  - Otherwise load FILL.
- tx_load:
  - Accepted only when tx_ready=1; it then clears tx_ready.
  - tx_load while tx_ready=0 is ignored.
  - tx_load in the same cycle as a shift-register load: the old holding word goes out first, the new word is captured and tx_ready=0.
- Abort: ss_n rising before DATA_W samples discards the partial word (rx_valid unchanged) and resets the counter. The tx holding word is retained if it was not yet consumed.
- rx_ack:
  - Clears rx_valid on the next clk.
  - If a word completes in the same cycle, completion wins: rx_valid stays 1 with the new data.
  - rx_data is overwritten on every completion regardless of rx_valid.
- cpol/cpha/lsbfe changes while busy=1 are undefined; the bench must not do it.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- When defined:
  - Adds ports rx_ovr (output, 1) and ovr_clr (input, 1).
  - rx_ovr sets (sticky) when a word completes while rx_valid=1 and rx_ack is not asserted that cycle.
  - ovr_clr clears it; a set in the same cycle wins.
  - Reset value 0.
- When undefined: the ports are absent and overrun is silent; the newest word overwrites rx_data.

Test Plan:
- Mode 0, lsbfe=0, tx_load 0x3C, master sends 0xA5 with sck=clk/8 → rx_data=0xA5, rx_valid=1 within 4 clk of the 8th rising sck; miso bits 0,0,1,1,1,1,0,0.
- Mode 3 (cpol=1, cpha=1), lsbfe=1, tx 0x81, master sends 0x5A → rx_data=0x5A; miso LSB-first 1,0,0,0,0,0,0,1 valid at each rising sck.
- ss_n held low for 3 frames 0x11,0x22,0x33, rx_ack after each, no tx_load → three rx_valid events with the matching data; miso=0xFF (FILL) every frame; tx_ready=1 throughout.
- ss_n deasserted after 5 bits, then a full 0xC3 frame → no rx_valid for the aborted frame; rx_data=0xC3 afterwards.
- Two frames without rx_ack (macro on) → rx_data=second word, rx_ovr=1; ovr_clr → rx_ovr=0. Macro off: same data, no overrun port.
- rst pulsed mid-frame after 4 bits, then a clean frame 0x96 → all outputs at reset values during rst; the next frame receives 0x96 correctly.

Source files
------------

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_rx
// Purpose  : SPI peripheral-side shift engine. It samples sck, ss_n and mosi
//            in the clk domain, assembles mosi bits into DATA_W-bit words,
//            and shifts a host-loaded word (or FILL) out on miso. It follows
//            the same cpol/cpha/lsbfe settings as the master. clk must run
//            at least 4x faster than sck.
// Ports    : clk, rst                - system clock, async active-high reset
//            cpol, cpha, lsbfe       - SPI mode and bit order (static in frame)
//            sck, ss_n, mosi         - asynchronous SPI pins in
//            miso, miso_oe           - serial data out and its drive enable
//            tx_data/tx_load/tx_ready- host transmit holding register
//            rx_data/rx_valid/rx_ack - received word and handshake
//            busy                    - frame in progress
//            rx_ovr, ovr_clr         - sticky overrun flag and its clear
//                                      (only when SPI_SLAVE_OVERRUN_EN is set)
// Options  : `define SPI_SLAVE_OVERRUN_EN adds overrun detection.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] FILL   = {DATA_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsbfe,
   input  logic              sck,
   input  logic              ss_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
`ifdef SPI_SLAVE_OVERRUN_EN
   output logic              rx_ovr,
   input  logic              ovr_clr,
`endif
   output logic              busy
);

   localparam int             CW     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0]  c_last = CW'(DATA_W - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t             r_state;
   logic               r_sck_meta, r_sck_sync, r_sck_dly;
   logic               r_ss_meta, r_ss_sync;
   logic               r_mosi_meta, r_mosi_sync;
   logic [CW-1:0]      r_cnt;
   logic [DATA_W-1:0]  r_rx_sr;
   logic [DATA_W-1:0]  r_tx_sr;
   logic [DATA_W-1:0]  r_hold;
   logic               r_tx_ready;
   logic               r_skip;    // cpha=1: next leading edge must not shift
   logic               r_reload;  // cpha=0: next trailing edge reloads
   logic               r_busy;
   logic [DATA_W-1:0]  r_rx_data;
   logic               r_rx_valid;

   logic               w_edge, w_lead, w_trail, w_sample, w_shift;
   logic               w_start, w_active, w_done, w_reload, w_load;
   logic               w_consume, w_accept;
   logic [DATA_W-1:0]  w_next_word, w_rx_next, w_tx_shifted;

   // ---------------- pin synchronisers ----------------
   // The sck synchroniser resets to the idle level so that leaving reset
   // never looks like a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sck_meta  <= cpol;
         r_sck_sync  <= cpol;
         r_sck_dly   <= cpol;
         r_ss_meta   <= 1'b1;
         r_ss_sync   <= 1'b1;
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_sck_meta  <= sck;
         r_sck_sync  <= r_sck_meta;
         r_sck_dly   <= r_sck_sync;
         r_ss_meta   <= ss_n;
         r_ss_sync   <= r_ss_meta;
         r_mosi_meta <= mosi;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   // ---------------- edge and event decode ----------------
   always_comb begin
      w_edge   = r_sck_sync ^ r_sck_dly;
      w_lead   = w_edge & (r_sck_sync != cpol);
      w_trail  = w_edge & (r_sck_sync == cpol);
      w_sample = cpha ? w_trail : w_lead;
      w_shift  = cpha ? w_lead  : w_trail;

      w_start  = (r_state == ST_IDLE)   & ~r_ss_sync;
      w_active = (r_state == ST_ACTIVE) & ~r_ss_sync;
      w_done   = w_active & w_sample & (r_cnt == c_last);
      w_reload = w_active & w_shift & ~cpha & r_reload;
      // Every point where the tx shift register takes a fresh word.
      w_load   = w_start | (w_done & cpha) | w_reload;

      w_next_word = r_tx_ready ? FILL : r_hold;
      w_consume   = w_load & ~r_tx_ready;
      // A load in the same cycle frees the holding register, so a new
      // tx_load is accepted even though tx_ready still reads 0.
      w_accept    = tx_load & (r_tx_ready | w_consume);

      w_rx_next    = lsbfe ? {r_mosi_sync, r_rx_sr[DATA_W-1:1]}
                           : {r_rx_sr[DATA_W-2:0], r_mosi_sync};
      w_tx_shifted = lsbfe ? {1'b0, r_tx_sr[DATA_W-1:1]}
                           : {r_tx_sr[DATA_W-2:0], 1'b0};
   end

   // ---------------- frame state machine ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_rx_sr   <= '0;
         r_tx_sr   <= '0;
         r_skip    <= 1'b0;
         r_reload  <= 1'b0;
         r_busy    <= 1'b0;
         r_rx_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               r_cnt  <= '0;
               if (w_start) begin
                  r_state  <= ST_ACTIVE;
                  r_busy   <= 1'b1;
                  r_tx_sr  <= w_next_word;
                  r_skip   <= cpha;
                  r_reload <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (r_ss_sync) begin
                  // Deselect: any partial word is dropped.
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  if (w_sample) begin
                     r_rx_sr <= w_rx_next;
                     if (w_done) begin
                        r_cnt     <= '0;
                        r_rx_data <= w_rx_next;
                        if (cpha) begin
                           r_tx_sr <= w_next_word;
                           r_skip  <= 1'b1;
                        end else begin
                           r_reload <= 1'b1;
                        end
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
                  if (w_shift) begin
                     if (cpha && r_skip) begin
                        r_skip <= 1'b0;
                     end else if (w_reload) begin
                        r_tx_sr  <= w_next_word;
                        r_reload <= 1'b0;
                     end else begin
                        r_tx_sr <= w_tx_shifted;
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // ---------------- tx holding register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold     <= '0;
         r_tx_ready <= 1'b1;
      end else if (w_accept) begin
         r_hold     <= tx_data;
         r_tx_ready <= 1'b0;
      end else if (w_consume) begin
         r_tx_ready <= 1'b1;
      end
   end

   // ---------------- rx handshake ----------------
   // Completion has priority over acknowledge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_valid <= 1'b0;
      end else if (w_done) begin
         r_rx_valid <= 1'b1;
      end else if (rx_ack) begin
         r_rx_valid <= 1'b0;
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   logic r_ovr;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovr <= 1'b0;
      end else if (w_done && r_rx_valid && !rx_ack) begin
         r_ovr <= 1'b1;
      end else if (ovr_clr) begin
         r_ovr <= 1'b0;
      end
   end
   assign rx_ovr = r_ovr;
`endif

   assign miso     = lsbfe ? r_tx_sr[0] : r_tx_sr[DATA_W-1];
   assign miso_oe  = r_busy;
   assign busy     = r_busy;
   assign tx_ready = r_tx_ready;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_rx
// Purpose  : Self-checking bench for spi_slave_rx. The bench acts as the SPI
//            master (sck = clk/8). Expected rx words go into a queue when a
//            frame is driven and are compared on every rx_valid rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
   logic       sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
   logic       miso, miso_oe, tx_ready, rx_valid, busy;
   logic [7:0] tx_data = 8'h00;
   logic       tx_load = 1'b0;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
   logic       rx_ovr;
   logic       ovr_clr = 1'b0;
`endif

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   bit         auto_ack   = 1'b1;
   bit         manual_ack = 1'b0;
   logic       prev_valid = 1'b0;

   spi_slave_rx #(.DATA_W(8), .FILL(8'hFF)) dut (
      .clk      (clk),
      .rst      (rst),
      .cpol     (cpol),
      .cpha     (cpha),
      .lsbfe    (lsbfe),
      .sck      (sck),
      .ss_n     (ss_n),
      .mosi     (mosi),
      .miso     (miso),
      .miso_oe  (miso_oe),
      .tx_data  (tx_data),
      .tx_load  (tx_load),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ack   (rx_ack),
`ifdef SPI_SLAVE_OVERRUN_EN
      .rx_ovr   (rx_ovr),
      .ovr_clr  (ovr_clr),
`endif
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor and rx_ack driver.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rx_valid && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rx_word: got %h, expected no word", rx_data);
            end else begin
               e = exp_q.pop_front();
               if (rx_data !== e) begin
                  failures++;
                  $display("FAIL rx_word: got %h, expected %h", rx_data, e);
               end
            end
         end
         prev_valid = rx_valid;
         rx_ack     = (auto_ack && rx_valid) || manual_ack;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic half();
      repeat (4) tick();
   endtask

   // Half period after the last sample edge, watching rx_valid latency.
   task automatic lat_wait();
      bit found = 1'b0;
      repeat (4) begin
         tick();
         if (rx_valid) found = 1'b1;
      end
      checks++;
      if (found !== 1'b1) begin
         failures++;
         $display("FAIL rx_latency: rx_valid seen=%0d, expected 1 within 4 clk", found);
      end
   endtask

   // Master side of nbits bit periods; ss_n is handled by the caller.
   task automatic xfer(input logic [7:0] d, input int nbits, input bit chk_lat,
                       output logic [7:0] mi);
      int idx;
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         idx = lsbfe ? i : 7 - i;
         if (!cpha) begin
            mosi = d[idx];
            half();
            sck = ~cpol;
            mi[idx] = miso;
            if (chk_lat && i == nbits - 1) lat_wait(); else half();
            sck = cpol;
         end else begin
            sck  = ~cpol;
            mosi = d[idx];
            half();
            sck = cpol;
            mi[idx] = miso;
            if (chk_lat && i == nbits - 1) lat_wait(); else half();
         end
      end
   endtask

   task automatic do_frame(input logic [7:0] d, output logic [7:0] mi);
      ss_n = 1'b0;
      half();
      xfer(d, 8, 1'b0, mi);
      half();
      ss_n = 1'b1;
      half();
   endtask

   task automatic load_tx(input logic [7:0] d);
      tx_data = d;
      tx_load = 1'b1;
      tick();
      tx_load = 1'b0;
   endtask

   task automatic set_mode(input logic p, input logic h, input logic l);
      cpol  = p;
      cpha  = h;
      lsbfe = l;
      sck   = p;
      repeat (6) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({miso, miso_oe, tx_ready, rx_data, rx_valid, busy} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_outputs: got %b, expected %b",
                  {miso, miso_oe, tx_ready, rx_data, rx_valid, busy},
                  {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
      end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_mode0();
      logic [7:0] mi;
      set_mode(1'b0, 1'b0, 1'b0);
      load_tx(8'h3C);
      checks++;
      if (tx_ready !== 1'b0) begin
         failures++;
         $display("FAIL m0_tx_ready_after_load: got %b, expected 0", tx_ready);
      end
      exp_q.push_back(8'hA5);
      ss_n = 1'b0;
      half();
      checks++;
      if ({busy, miso_oe} !== 2'b11) begin
         failures++;
         $display("FAIL m0_busy_oe: got %b, expected 11", {busy, miso_oe});
      end
      xfer(8'hA5, 8, 1'b1, mi);
      half();
      ss_n = 1'b1;
      half();
      checks++;
      if (mi !== 8'h3C) begin
         failures++;
         $display("FAIL m0_miso: got %h, expected 3c", mi);
      end
      checks++;
      if (rx_data !== 8'hA5) begin
         failures++;
         $display("FAIL m0_rx_data: got %h, expected a5", rx_data);
      end
      checks++;
      if ({tx_ready, busy, miso_oe, rx_valid} !== 4'b1000) begin
         failures++;
         $display("FAIL m0_idle_flags: got %b, expected 1000", {tx_ready, busy, miso_oe, rx_valid});
      end
   endtask

   task automatic test_mode3_lsb();
      logic [7:0] mi;
      set_mode(1'b1, 1'b1, 1'b1);
      load_tx(8'h81);
      exp_q.push_back(8'h5A);
      ss_n = 1'b0;
      half();
      xfer(8'h5A, 8, 1'b1, mi);
      half();
      ss_n = 1'b1;
      half();
      checks++;
      if (mi !== 8'h81) begin
         failures++;
         $display("FAIL m3_miso: got %h, expected 81", mi);
      end
      checks++;
      if (rx_data !== 8'h5A) begin
         failures++;
         $display("FAIL m3_rx_data: got %h, expected 5a", rx_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] mi;
      logic [7:0] words [3];
      words[0] = 8'h11;
      words[1] = 8'h22;
      words[2] = 8'h33;
      set_mode(1'b0, 1'b0, 1'b0);
      ss_n = 1'b0;
      half();
      for (int f = 0; f < 3; f++) begin
         exp_q.push_back(words[f]);
         xfer(words[f], 8, 1'b0, mi);
         checks++;
         if (mi !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_miso_fill: frame %0d got %h, expected ff", f, mi);
         end
         checks++;
         if (tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_tx_ready: frame %0d got %b, expected 1", f, tx_ready);
         end
      end
      half();
      ss_n = 1'b1;
      half();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL b2b_words_seen: pending %0d, expected 0", exp_q.size());
      end
   endtask

   task automatic test_abort();
      logic [7:0] mi;
      set_mode(1'b0, 1'b0, 1'b0);
      ss_n = 1'b0;
      half();
      load_tx(8'h5E);
      xfer(8'h3A, 5, 1'b0, mi);
      half();
      ss_n = 1'b1;
      half();
      checks++;
      if ({tx_ready, rx_valid, busy} !== 3'b000) begin
         failures++;
         $display("FAIL abort_flags: got %b, expected 000", {tx_ready, rx_valid, busy});
      end
      exp_q.push_back(8'hC3);
      do_frame(8'hC3, mi);
      checks++;
      if (mi !== 8'h5E) begin
         failures++;
         $display("FAIL abort_tx_retained: got %h, expected 5e", mi);
      end
      checks++;
      if (rx_data !== 8'hC3) begin
         failures++;
         $display("FAIL abort_rx_data: got %h, expected c3", rx_data);
      end
   endtask

   task automatic test_overrun();
      logic [7:0] mi;
      set_mode(1'b0, 1'b0, 1'b0);
      auto_ack = 1'b0;
      exp_q.push_back(8'h12);
      do_frame(8'h12, mi);
`ifdef SPI_SLAVE_OVERRUN_EN
      checks++;
      if (rx_ovr !== 1'b0) begin
         failures++;
         $display("FAIL ovr_early: got %b, expected 0", rx_ovr);
      end
`endif
      do_frame(8'h34, mi);
      checks++;
      if ({rx_data, rx_valid} !== {8'h34, 1'b1}) begin
         failures++;
         $display("FAIL ovr_data: got %h/%b, expected 34/1", rx_data, rx_valid);
      end
`ifdef SPI_SLAVE_OVERRUN_EN
      checks++;
      if (rx_ovr !== 1'b1) begin
         failures++;
         $display("FAIL ovr_set: got %b, expected 1", rx_ovr);
      end
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      checks++;
      if (rx_ovr !== 1'b0) begin
         failures++;
         $display("FAIL ovr_clear: got %b, expected 0", rx_ovr);
      end
`endif
      manual_ack = 1'b1;
      tick();
      manual_ack = 1'b0;
      repeat (2) tick();
      checks++;
      if (rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL ovr_ack: got %b, expected 0", rx_valid);
      end
      auto_ack = 1'b1;
   endtask

   task automatic test_reset_midframe();
      logic [7:0] mi;
      set_mode(1'b0, 1'b0, 1'b0);
      ss_n = 1'b0;
      half();
      xfer(8'hF0, 4, 1'b0, mi);
      rst = 1'b1;
      tick();
      checks++;
      if ({miso, miso_oe, tx_ready, rx_data, rx_valid, busy} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL midrst_outputs: got %b, expected %b",
                  {miso, miso_oe, tx_ready, rx_data, rx_valid, busy},
                  {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
      end
      ss_n = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      half();
      exp_q.push_back(8'h96);
      do_frame(8'h96, mi);
      checks++;
      if ({rx_data, mi} !== {8'h96, 8'hFF}) begin
         failures++;
         $display("FAIL midrst_frame: got rx %h miso %h, expected rx 96 miso ff", rx_data, mi);
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode3_lsb();
      test_back_to_back();
      test_abort();
      test_overrun();
      test_reset_midframe();
      repeat (8) tick();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL words_outstanding: pending %0d, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
